// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Round-robin fetch/loader sequencer for a single-port sync-read IMEM
// Revision : 1.0
// ============================================================================
module imem_arbiter #(
    parameter int XLEN              = 32,
    parameter int DEPTH_WORDS       = 1024,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           f_req_valid,
    output logic                           f_req_ready,
    input  logic [XLEN-1:0]                f_req_addr,
    input  logic                           f_flush,
    output logic                           f_rsp_valid,
    input  logic                           f_rsp_ready,
    output logic [INSTRUCTION_WIDTH-1:0]   f_rsp_data,
    output logic                           f_rsp_err,
    input  logic                           l_req_valid,
    output logic                           l_req_ready,
    input  logic                           l_req_we,
    input  logic [XLEN-1:0]                l_req_addr,
    input  logic [INSTRUCTION_WIDTH-1:0]   l_req_wdata,
    output logic                           l_rsp_valid,
    input  logic                           l_rsp_ready,
    output logic [INSTRUCTION_WIDTH-1:0]   l_rsp_data,
    output logic                           l_rsp_err,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0]   mem_wdata,
    input  logic [INSTRUCTION_WIDTH-1:0]   mem_rdata
);

    localparam int INSTRUCTION_BYTES = INSTRUCTION_WIDTH / 8;
    localparam int AW                = $clog2(DEPTH_WORDS);
    localparam int BW                = $clog2(INSTRUCTION_BYTES);
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH_WORDS * INSTRUCTION_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_FETCH  = 1'b0;
    localparam logic OWN_LOADER = 1'b1;

    logic [1:0]                   state;
    logic [1:0]                   state_nxt;
    logic                         owner;
    logic                         last_grant;
    logic                         is_write;
    logic [INSTRUCTION_WIDTH-1:0] rsp_data;
    logic                         rsp_err;

    logic            fetch_cand;
    logic            grant_fetch;
    logic            grant_loader;
    logic            rsp_hs;
    logic            window;
    logic            accept;
    logic [XLEN-1:0] sel_addr;
    logic            misalign;
    logic            fault;
    logic            flush_hit;

    // A flushing fetch never competes, so the loader can take the slot instead
    assign fetch_cand   = f_req_valid & ~f_flush;
    assign grant_fetch  = fetch_cand & (~l_req_valid | (last_grant == OWN_LOADER));
    assign grant_loader = l_req_valid & ~grant_fetch;

    assign rsp_hs    = (state == S_RESP) & ((owner == OWN_LOADER) ? l_rsp_ready : f_rsp_ready);
    assign window    = rst_n & ((state == S_IDLE) | rsp_hs);
    assign accept    = window & (grant_fetch | grant_loader);
    assign sel_addr  = grant_loader ? l_req_addr : f_req_addr;
    assign fault     = (sel_addr >= ADDR_LIMIT) | misalign;
    assign flush_hit = f_flush & (owner == OWN_FETCH) & ((state == S_MEM) | (state == S_RESP));

    generate
        if (BW > 0) begin : g_align
            assign misalign = |sel_addr[BW-1:0];
        end else begin : g_no_align
            assign misalign = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = fault ? S_RESP : S_MEM;
            end
            S_MEM: begin
                state_nxt = flush_hit ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (accept)                 state_nxt = fault ? S_RESP : S_MEM;
                else if (rsp_hs || flush_hit) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_FETCH;
            last_grant <= OWN_LOADER;
            is_write   <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            owner      <= grant_loader;
            last_grant <= grant_loader;
            is_write   <= grant_loader & l_req_we;
            if (fault) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end else if (state == S_MEM) begin
            rsp_data <= is_write ? '0 : mem_rdata;
            rsp_err  <= 1'b0;
        end
    end

    always_comb begin
        f_req_ready = window & grant_fetch;
        l_req_ready = window & grant_loader;
        mem_en      = accept & ~fault;
        mem_we      = accept & ~fault & grant_loader & l_req_we;
        mem_addr    = sel_addr[AW+BW-1:BW];
        mem_wdata   = l_req_wdata;
        f_rsp_valid = (state == S_RESP) & (owner == OWN_FETCH);
        l_rsp_valid = (state == S_RESP) & (owner == OWN_LOADER);
        f_rsp_data  = f_rsp_valid ? rsp_data : '0;
        f_rsp_err   = f_rsp_valid & rsp_err;
        l_rsp_data  = l_rsp_valid ? rsp_data : '0;
        l_rsp_err   = l_rsp_valid & rsp_err;
    end

endmodule
`default_nettype wire
